// File: rtl/ulpi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ulpi_pkg
//  Description : Shared ULPI definitions. Holds the TX CMD prefixes for
//                register access, the PHY register addresses the link
//                programs at bring-up, and the state encoding of the
//                register-access engine.
//  Revision    : 1.0  initial release
// ============================================================================
package ulpi_pkg;

    // TX CMD byte = {prefix, 6-bit immediate address}
    localparam logic [1:0] ULPI_CMD_REGW = 2'b10;
    localparam logic [1:0] ULPI_CMD_REGR = 2'b11;

    // PHY register addresses
    localparam logic [5:0] FUNC_CTRL = 6'h04;
    localparam logic [5:0] OTG_CTRL  = 6'h0A;
    localparam logic [5:0] SCRATCH   = 6'h16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_WDATA    = 3'd2,
        ST_STP      = 3'd3,
        ST_RD_TURN  = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_WAIT_BUS = 3'd6
    } ulpi_state_e;

    // Builds the immediate-address register TX CMD byte.
    function automatic logic [7:0] ulpi_tx_cmd(input logic       write,
                                               input logic [5:0] addr);
        return {(write ? ULPI_CMD_REGW : ULPI_CMD_REGR), addr};
    endfunction

endpackage : ulpi_pkg
`default_nettype wire

// File: rtl/ulpi_reg_access.sv
`default_nettype none
// ============================================================================
//  Module      : ulpi_reg_access
//  Description : Link-side ULPI register-access engine. Issues PHY register
//                write/read TX CMDs on the shared ULPI bus, yields the bus
//                whenever the PHY asserts dir (retrying the command later),
//                and returns completion / read data on a request/response
//                interface. A per-request timer aborts with an error
//                response after TIMEOUT_CYCLES.
//  Ports       : clk_i, rst_i            ULPI clock, sync active-high reset
//                ulpi_data_i/o, ulpi_dir_i, ulpi_nxt_i, ulpi_stp_o
//                                        ULPI link signals (tri-state at top)
//                req_valid_i/ready_o, req_write_i, req_addr_i, req_data_i
//                                        register access request
//                resp_valid_o, resp_data_o, resp_err_o
//                                        one-cycle completion pulse
//                busy_o                  request pending
//  Revision    : 1.0  initial release
// ============================================================================
module ulpi_reg_access
    import ulpi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic       ulpi_stp_o,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_write_i,
    input  logic [5:0] req_addr_i,
    input  logic [7:0] req_data_i,
    output logic       resp_valid_o,
    output logic [7:0] resp_data_o,
    output logic       resp_err_o,
    output logic       busy_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    // The timer reads k in the k-th cycle after acceptance. A TX abort needs
    // one extra cycle in STP, so it is decided one cycle earlier than an
    // abort from the other states; both land the error response exactly
    // TIMEOUT_CYCLES after acceptance.
    localparam logic [TW-1:0] TX_LIMIT   = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_ONE    = TW'(1);

    ulpi_state_e   state_q, state_d;
    logic          dir_q;
    logic          pending_q, pending_d;
    logic          abort_q, abort_d;
    logic          write_q, write_d;
    logic [5:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          resp_valid_q, resp_valid_d;
    logic [7:0]    resp_data_q, resp_data_d;
    logic          resp_err_q, resp_err_d;

    logic          req_fire;
    logic          tx_expire;
    logic          expire;

    // A turnaround cycle is needed after dir falls, hence the dir_q term.
    assign req_ready_o = (state_q == ST_IDLE) & ~ulpi_dir_i & ~dir_q;
    assign req_fire    = req_valid_i & req_ready_o;

    assign tx_expire = pending_q & (timer_q >= TX_LIMIT);
    assign expire    = pending_q & (timer_q >= IDLE_LIMIT);

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;
    assign busy_o       = req_fire | pending_q | resp_valid_q;

    // Bus drive is a pure decode of the state register, so the write data
    // byte can only appear after WDATA was entered on a TX CMD nxt.
    always_comb begin
        ulpi_data_o = 8'h00;
        ulpi_stp_o  = 1'b0;
        case (state_q)
            ST_CMD:   ulpi_data_o = ulpi_tx_cmd(write_q, addr_q);
            ST_WDATA: ulpi_data_o = wdata_q;
            ST_STP:   ulpi_stp_o  = 1'b1;
            default:  ulpi_data_o = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        abort_d      = abort_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        timer_d      = pending_q ? (timer_q + TMR_ONE) : timer_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    write_d   = req_write_i;
                    addr_d    = req_addr_i;
                    wdata_d   = req_data_i;
                    pending_d = 1'b1;
                    abort_d   = 1'b0;
                    timer_d   = TMR_ONE;
                    state_d   = ST_CMD;
                end
            end

            ST_CMD: begin
                if (tx_expire) begin
                    abort_d = 1'b1;
                    state_d = ST_STP;
                end else if (ulpi_dir_i) begin
                    state_d = ST_WAIT_BUS;
                end else if (ulpi_nxt_i) begin
                    state_d = write_q ? ST_WDATA : ST_RD_TURN;
                end
            end

            ST_WDATA: begin
                if (tx_expire) begin
                    abort_d = 1'b1;
                    state_d = ST_STP;
                end else if (ulpi_dir_i) begin
                    state_d = ST_WAIT_BUS;
                end else if (ulpi_nxt_i) begin
                    state_d = ST_STP;
                end
            end

            // Completes both a normal write and a timed-out TX command.
            ST_STP: begin
                state_d      = ST_IDLE;
                pending_d    = 1'b0;
                resp_valid_d = 1'b1;
                resp_err_d   = abort_q;
                resp_data_d  = abort_q ? 8'h00 : wdata_q;
            end

            ST_RD_TURN: begin
                if (expire) begin
                    pending_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = 8'h00;
                    state_d      = ulpi_dir_i ? ST_WAIT_BUS : ST_IDLE;
                end else if (ulpi_dir_i && !ulpi_nxt_i) begin
                    state_d = ST_RD_DATA;
                end else if (ulpi_dir_i && ulpi_nxt_i) begin
                    // RX CMD preempted the read; retry once the bus is free.
                    state_d = ST_WAIT_BUS;
                end
            end

            ST_RD_DATA: begin
                pending_d    = 1'b0;
                resp_valid_d = 1'b1;
                resp_data_d  = ulpi_data_i;
                state_d      = ST_WAIT_BUS;
            end

            ST_WAIT_BUS: begin
                if (expire) begin
                    pending_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = 8'h00;
                    state_d      = ulpi_dir_i ? ST_WAIT_BUS : ST_IDLE;
                end else if (!(ulpi_dir_i || dir_q)) begin
                    state_d = pending_q ? ST_CMD : ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            pending_q    <= 1'b0;
            abort_q      <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= 6'h00;
            wdata_q      <= 8'h00;
            timer_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 8'h00;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= ulpi_dir_i;
            pending_q    <= pending_d;
            abort_q      <= abort_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            timer_q      <= timer_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule : ulpi_reg_access
`default_nettype wire
